// File: rtl/axi4_burst_master.sv
// axi4_burst_master: start-triggered AXI4 master that writes NOPS operand bursts and reads back one result burst,
// retrying bad responses up to MAX_RETRY times per burst.
module axi4_burst_master #(
    parameter int OPW       = 32,
    parameter int NOPS      = 2,
    parameter int DSZ       = 8,
    parameter int ASZ       = 4,
    parameter int RESW      = 64,
    parameter int RES_ADDR  = 0,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [NOPS*OPW-1:0] ops_i,
    output logic [RESW-1:0]     res_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [ASZ-1:0]      awaddr_o,
    output logic [7:0]          awlen_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DSZ-1:0]      wdata_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    output logic                wlast_o,
    input  logic                bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic [ASZ-1:0]      araddr_o,
    output logic [7:0]          arlen_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DSZ-1:0]      rdata_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    input  logic                rlast_i,
    input  logic                rresp_i
);
    localparam int WB = OPW / DSZ;
    localparam int RB = RESW / DSZ;
    localparam int BW = $clog2(WB + 1);
    localparam int PW = $clog2(RB + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN, FAIL} state_t;
    state_t              state_q;
    logic [NOPS*OPW-1:0] ops_q;
    logic [OPW-1:0]      wsh_q;
    logic [RESW-1:0]     rsh_q, res_q, rsh_d;
    logic [BW-1:0]       beat_q;
    logic [PW-1:0]       rpos_q;
    logic [RW-1:0]       retry_q;
    logic [ASZ-1:0]      idx_q, awaddr_q, araddr_q;
    logic [7:0]          awlen_q, arlen_q;
    logic [DSZ-1:0]      wdata_q;
    logic busy_q, done_q, err_q, awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q, bad_q;
    logic rlast_exp_d, bad_d, rend_d, can_retry_d;
    always_comb begin
        rlast_exp_d = rpos_q == PW'(RB - 1);
        bad_d       = bad_q | ~rresp_i | (rlast_i != rlast_exp_d);
        rend_d      = rlast_i | rlast_exp_d;
        can_retry_d = retry_q < RW'(MAX_RETRY);
        rsh_d       = (rsh_q >> DSZ) | (RESW'(rdata_i) << (RESW - DSZ));
    end
    // ops_q shifts one operand down per accepted burst, so the current operand always sits at the bottom
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ops_q     <= '0;
            wsh_q     <= '0;
            rsh_q     <= '0;
            res_q     <= '0;
            beat_q    <= '0;
            rpos_q    <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            awlen_q   <= '0;
            arlen_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    ops_q     <= ops_i;
                    busy_q    <= 1'b1;
                    idx_q     <= '0;
                    retry_q   <= '0;
                    awvalid_q <= 1'b1;
                    awaddr_q  <= '0;
                    awlen_q   <= 8'(WB - 1);
                    state_q   <= AW;
                end
                AW: if (awready_i) begin
                    awvalid_q <= 1'b0;
                    wdata_q   <= ops_q[DSZ-1:0];
                    wsh_q     <= ops_q[OPW-1:0] >> DSZ;
                    wvalid_q  <= 1'b1;
                    wlast_q   <= (WB == 1);
                    beat_q    <= BW'(1);
                    state_q   <= W;
                end
                W: if (wready_i) begin
                    if (wlast_q) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        wdata_q  <= '0;
                        bready_q <= 1'b1;
                        state_q  <= B;
                    end else begin
                        wdata_q <= wsh_q[DSZ-1:0];
                        wsh_q   <= wsh_q >> DSZ;
                        wlast_q <= beat_q == BW'(WB - 1);
                        beat_q  <= beat_q + 1'b1;
                    end
                end
                B: if (bvalid_i) begin
                    bready_q <= 1'b0;
                    if (bresp_i) begin
                        retry_q <= '0;
                        if (idx_q == ASZ'(NOPS - 1)) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= ASZ'(RES_ADDR);
                            arlen_q   <= 8'(RB - 1);
                            state_q   <= AR;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            ops_q     <= ops_q >> OPW;
                            awaddr_q  <= idx_q + 1'b1;
                            awvalid_q <= 1'b1;
                            state_q   <= AW;
                        end
                    end else if (can_retry_d) begin
                        retry_q   <= retry_q + 1'b1;
                        awvalid_q <= 1'b1;
                        state_q   <= AW;
                    end else begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= FAIL;
                    end
                end
                AR: if (arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    rpos_q    <= '0;
                    bad_q     <= 1'b0;
                    state_q   <= R;
                end
                R: if (rvalid_i) begin
                    rsh_q  <= rsh_d;
                    rpos_q <= rpos_q + 1'b1;
                    bad_q  <= bad_d;
                    if (rend_d) begin
                        rready_q <= 1'b0;
                        if (!bad_d) begin
                            res_q   <= rsh_d;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else if (can_retry_d) begin
                            retry_q   <= retry_q + 1'b1;
                            arvalid_q <= 1'b1;
                            state_q   <= AR;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= FAIL;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                FAIL: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign res_o     = res_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign awaddr_o  = awaddr_q;
    assign awlen_o   = awlen_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wdata_q;
    assign wvalid_o  = wvalid_q;
    assign wlast_o   = wlast_q;
    assign bready_o  = bready_q;
    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: AXI slave model plus transaction-level reference for axi4_burst_master,
// with directed retry/error/reset cases, random backpressure and a DSZ=16 variant.
module tb_axi4_burst_master;
    localparam int OPW = 32, NOPS = 2, DSZ = 8, ASZ = 4, RESW = 64, MAXR = 2;
    localparam int WB = OPW / DSZ, RB = RESW / DSZ;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [NOPS*OPW-1:0] ops = '0;
    logic [RESW-1:0] res;
    logic busy, done, err, awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [ASZ-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [DSZ-1:0] wdata;
    logic awready = 1'b0, wready = 1'b0, bresp = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic rvalid = 1'b0, rlast = 1'b0, rresp = 1'b0;
    logic [DSZ-1:0] rdata = '0;
    logic d_start = 1'b0;
    logic [NOPS*OPW-1:0] d_ops = '0;
    logic [RESW-1:0] d_res;
    logic d_busy, d_done, d_err, d_awvalid, d_wvalid, d_wlast, d_bready, d_arvalid, d_rready;
    logic [ASZ-1:0] d_awaddr, d_araddr;
    logic [7:0] d_awlen, d_arlen;
    logic [15:0] d_wdata;
    int total = 0, bad = 0;
    int mode = 0, b_pend = 0, b_cnt = 0, r_cnt = 0;
    bit bpol[16];
    int rlpol[8];
    bit rrpol[8];
    logic [RESW-1:0] rword = '0, exp_res = '0;
    int aw_log[$], awlen_log[$], w_log[$], ar_log[$], arlen_log[$];
    bit wl_log[$];
    int exp_aw[$], exp_w[$];
    bit exp_wl[$];
    int exp_nar = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    axi4_burst_master u_dut (
        .clk(clk), .rst(rst), .start_i(start), .ops_i(ops), .res_o(res), .busy_o(busy), .done_o(done), .err_o(err),
        .awaddr_o(awaddr), .awlen_o(awlen), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wvalid_o(wvalid), .wready_i(wready), .wlast_o(wlast),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
        .araddr_o(araddr), .arlen_o(arlen), .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready), .rlast_i(rlast), .rresp_i(rresp)
    );

    axi4_burst_master #(.DSZ(16)) u_dut16 (
        .clk(clk), .rst(rst), .start_i(d_start), .ops_i(d_ops), .res_o(d_res), .busy_o(d_busy), .done_o(d_done),
        .err_o(d_err), .awaddr_o(d_awaddr), .awlen_o(d_awlen), .awvalid_o(d_awvalid), .awready_i(1'b1),
        .wdata_o(d_wdata), .wvalid_o(d_wvalid), .wready_i(1'b1), .wlast_o(d_wlast),
        .bresp_i(1'b0), .bvalid_i(1'b0), .bready_o(d_bready),
        .araddr_o(d_araddr), .arlen_o(d_arlen), .arvalid_o(d_arvalid), .arready_i(1'b0),
        .rdata_i(16'h0), .rvalid_i(1'b0), .rready_o(d_rready), .rlast_i(1'b0), .rresp_i(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic set_pol();
        for (int j = 0; j < 16; j++) bpol[j] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            rlpol[j] = RB - 1;
            rrpol[j] = 1'b1;
        end
    endtask

    // Transaction-level expectation: bursts per operand with bounded retries, then read attempts.
    function automatic void build_model(input logic [NOPS*OPW-1:0] o, input logic [RESW-1:0] prev);
        int bi = 0, tries;
        bit ok;
        exp_aw.delete();
        exp_w.delete();
        exp_wl.delete();
        exp_nar = 0;
        exp_err = 1'b0;
        exp_res = prev;
        for (int i = 0; i < NOPS; i++) begin
            tries = 0;
            ok = 1'b0;
            while (!ok && tries <= MAXR) begin
                exp_aw.push_back(i);
                for (int k = 0; k < WB; k++) begin
                    exp_w.push_back(int'(o[i*OPW + k*DSZ +: DSZ]));
                    exp_wl.push_back(k == WB - 1);
                end
                ok = bpol[bi];
                bi++;
                tries++;
            end
            if (!ok) begin
                exp_err = 1'b1;
                return;
            end
        end
        tries = 0;
        ok = 1'b0;
        while (!ok && tries <= MAXR) begin
            ok = rrpol[exp_nar] && rlpol[exp_nar] == RB - 1;
            exp_nar++;
            tries++;
        end
        if (ok) exp_res = rword;
        else exp_err = 1'b1;
    endfunction

    task automatic clear_logs();
        aw_log.delete();
        awlen_log.delete();
        w_log.delete();
        wl_log.delete();
        ar_log.delete();
        arlen_log.delete();
        b_cnt = 0;
        r_cnt = 0;
    endtask

    task automatic run(input string tag, input logic [NOPS*OPW-1:0] o);
        int n = 0;
        build_model(o, res);
        clear_logs();
        ops = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ":busy"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":done"}, 64'(done), 64'd1);
        chk({tag, ":err"}, 64'(err), 64'(exp_err));
        chk({tag, ":res"}, res, exp_res);
        chk({tag, ":busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, ":done_pulse"}, 64'({done, err}), 64'd0);
        chk({tag, ":busy_end"}, 64'(busy), 64'd0);
        chk({tag, ":n_aw"}, 64'(aw_log.size()), 64'(exp_aw.size()));
        for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++) begin
            chk({tag, ":awaddr"}, 64'(aw_log[i]), 64'(exp_aw[i]));
            chk({tag, ":awlen"}, 64'(awlen_log[i]), 64'(WB - 1));
        end
        chk({tag, ":n_w"}, 64'(w_log.size()), 64'(exp_w.size()));
        for (int i = 0; i < w_log.size() && i < exp_w.size(); i++)
            chk({tag, ":wbeat"}, 64'({w_log[i], wl_log[i]}), 64'({exp_w[i], exp_wl[i]}));
        chk({tag, ":n_ar"}, 64'(ar_log.size()), 64'(exp_nar));
        for (int i = 0; i < ar_log.size(); i++)
            chk({tag, ":ar"}, 64'({ar_log[i], arlen_log[i]}), 64'({32'd0, RB - 1}));
    endtask

    // Slave: decides ready/valid at each falling edge; a handshake seen here completes on the next rising edge.
    initial begin
        bit tog = 1'b0, w_st = 1'b0;
        logic [DSZ-1:0] pd = '0;
        logic pl = 1'b0;
        int aw_wait = 0, r_left = 0, r_idx = 0, r_cur = 0;
        forever begin
            @(negedge clk);
            tog = ~tog;
            if (rst) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                w_st = 1'b0; b_pend = 0; r_left = 0; aw_wait = 0;
            end else begin
                total++;
                assert (int'(awvalid) + int'(wvalid) + int'(arvalid) <= 1) else begin
                    bad++;
                    $error("FAIL onevalid got=%0d want<=1", int'(awvalid) + int'(wvalid) + int'(arvalid));
                end
                if (w_st && wvalid) chk("w_stable", 64'({wdata, wlast}), 64'({pd, pl}));
                bvalid = b_pend > 0 && (mode != 2 || $urandom_range(0, 1) == 1);
                bresp = bpol[b_cnt];
                if (bvalid && bready) begin
                    b_pend--;
                    b_cnt++;
                end
                rvalid = r_left > 0 && (mode == 0 || (mode == 1 ? tog : $urandom_range(0, 1) == 1));
                rdata = r_left > 0 ? rword[r_idx*DSZ +: DSZ] : '0;
                rlast = rvalid && r_left == 1;
                rresp = rrpol[r_cur];
                if (rvalid && rready) begin
                    r_idx++;
                    r_left--;
                end
                awready = awvalid && (mode == 2 ? $urandom_range(0, 1) == 1 : aw_wait >= (mode == 1 ? 3 : 0));
                if (awvalid && !awready) aw_wait++;
                if (awvalid && awready) begin
                    aw_log.push_back(int'(awaddr));
                    awlen_log.push_back(int'(awlen));
                    aw_wait = 0;
                end
                wready = mode == 0 || (mode == 1 ? tog : $urandom_range(0, 1) == 1);
                if (wvalid && wready) begin
                    w_log.push_back(int'(wdata));
                    wl_log.push_back(wlast);
                    if (wlast) b_pend++;
                end
                w_st = wvalid && !wready;
                pd = wdata;
                pl = wlast;
                arready = arvalid && (mode != 2 || $urandom_range(0, 1) == 1);
                if (arvalid && arready) begin
                    ar_log.push_back(int'(araddr));
                    arlen_log.push_back(int'(arlen));
                    r_left = rlpol[r_cnt] + 1;
                    r_idx = 0;
                    r_cur = r_cnt;
                    r_cnt++;
                end
            end
        end
    end

    initial begin
        int n;
        set_pol();
        repeat (3) @(negedge clk);
        chk("rst:ctl", 64'({busy, done, err, awvalid, wvalid, wlast, bready, arvalid, rready}), 64'd0);
        chk("rst:bus", 64'({wdata, awaddr, awlen, araddr, arlen}), 64'd0);
        chk("rst:res", res, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rword = 64'h1122334455667788;
        mode = 0;
        run("basic", {32'h08070605, 32'h04030201});
        mode = 1;
        run("bkpr", {32'h08070605, 32'h04030201});
        mode = 0;
        rword = 64'hA5A5_0F0F_1234_5678;
        bpol[1] = 1'b0;
        run("wretry", {32'hDEADBEEF, 32'hCAFEF00D});
        chk("wretry:aw3", 64'(aw_log.size() > 2 ? aw_log[2] : -1), 64'd1);
        for (int j = 0; j < 16; j++) bpol[j] = 1'b0;
        run("wfail", {32'h01010101, 32'h02020202});
        set_pol();
        rword = 64'h0102030405060708;
        rlpol[0] = 4;
        run("rearly", {32'h11111111, 32'h22222222});
        set_pol();
        for (int j = 0; j < 8; j++) rrpol[j] = 1'b0;
        rword = 64'hFFFF_0000_FFFF_0000;
        run("rfail", {32'h33333333, 32'h44444444});
        set_pol();
        clear_logs();
        ops = {32'h08070605, 32'h04030201};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (w_log.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midw:reached", 64'(w_log.size() >= 2), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midw:ctl", 64'({busy, done, err, awvalid, wvalid, wlast, bready, arvalid, rready}), 64'd0);
        chk("midw:bus", 64'({wdata, awaddr, awlen, araddr, arlen}), 64'd0);
        chk("midw:res", res, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rword = 64'h1122334455667788;
        run("after_rst", {32'h08070605, 32'h04030201});
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 16; j++) bpol[j] = $urandom_range(0, 3) != 0;
            for (int j = 0; j < 8; j++) begin
                rlpol[j] = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, RB - 2)) : RB - 1;
                rrpol[j] = $urandom_range(0, 4) != 0;
            end
            rword = {$urandom, $urandom};
            mode = 2;
            run("rnd", {$urandom, $urandom});
        end
        mode = 0;
        d_ops = {32'h08070605, 32'h04030201};
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        chk("d16:aw", 64'({d_awvalid, d_awlen, d_awaddr}), 64'({1'b1, 8'd1, 4'd0}));
        @(negedge clk);
        chk("d16:beat0", 64'({d_wvalid, d_wdata, d_wlast}), 64'({1'b1, 16'h0201, 1'b0}));
        @(negedge clk);
        chk("d16:beat1", 64'({d_wvalid, d_wdata, d_wlast}), 64'({1'b1, 16'h0403, 1'b1}));
        @(negedge clk);
        chk("d16:b", 64'({d_wvalid, d_bready}), 64'({1'b0, 1'b1}));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
